// File: rtl/r6_vsum.sv
// Vertical running-sum front end of the R6 sliding-window path: one column sum
// over the last 2R+1 rows per accepted pixel, plus frame status for the row controller.
module r6_vsum #(
  parameter int COLS   = 15,
  parameter int ROWS   = 15,
  parameter int DATA_W = 8,
  parameter int R      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W+3:0] sum_o,
  output logic [9:0]        col_o,
  output logic [9:0]        row_o,
  output logic              done_o,
  output logic [9:0]        counter_o,
  output logic              row_eq_max_o,
  output logic              busy_o
);
  localparam int WIN = 2*R + 1;
  localparam int SW  = DATA_W + 4;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = $clog2(WIN);
  localparam logic [9:0]    WIN10  = 10'(WIN);
  localparam logic [9:0]    WIN_M1 = 10'(WIN - 1);
  localparam logic [9:0]    R10    = 10'(R);
  localparam logic [9:0]    C_LAST = 10'(COLS - 1);
  localparam logic [9:0]    R_LAST = 10'(ROWS - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(WIN - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            r_state;
  logic [9:0]        r_col, r_row;
  logic [RW-1:0]     r_ring;
  logic [SW-1:0]     r_sum  [COLS];
  logic [DATA_W-1:0] r_hist [WIN][COLS];

  logic              w_acc;
  logic [CW-1:0]     w_cidx;
  logic [DATA_W-1:0] w_old;
  logic [SW-1:0]     w_sum_new;

  // A start_i in any state wins over a coinciding pixel.
  assign w_acc     = (r_state == FILL) && valid_i && !start_i;
  assign w_cidx    = r_col[CW-1:0];
  // History slot is only meaningful once a full window of rows has been written.
  assign w_old     = (r_row >= WIN10) ? r_hist[r_ring][w_cidx] : '0;
  assign w_sum_new = r_sum[w_cidx] + SW'(data_i) - SW'(w_old);
  assign counter_o = r_col;

  always_ff @(posedge clk) begin
    if (w_acc) r_hist[r_ring][w_cidx] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_ring       <= '0;
      for (int i = 0; i < COLS; i++) r_sum[i] <= '0;
      valid_o      <= 1'b0;
      sum_o        <= '0;
      col_o        <= '0;
      row_o        <= '0;
      done_o       <= 1'b0;
      row_eq_max_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      if (start_i) begin
        r_state      <= FILL;
        r_col        <= '0;
        r_row        <= '0;
        r_ring       <= '0;
        for (int i = 0; i < COLS; i++) r_sum[i] <= '0;
        row_eq_max_o <= 1'b0;
        busy_o       <= 1'b1;
      end else if (w_acc) begin
        r_sum[w_cidx] <= w_sum_new;
        if (r_col == C_LAST) begin
          r_col  <= '0;
          r_row  <= r_row + 10'd1;
          r_ring <= (r_ring == RING_LAST) ? '0 : r_ring + RW'(1);
        end else begin
          r_col <= r_col + 10'd1;
        end
        if (r_row >= WIN_M1) begin
          valid_o <= 1'b1;
          sum_o   <= w_sum_new;
          col_o   <= r_col;
          row_o   <= r_row - R10;
          done_o  <= (r_row == WIN_M1) && (r_col == '0);
        end
        if (r_row == R_LAST && r_col == C_LAST) begin
          r_state      <= DONE;
          row_eq_max_o <= 1'b1;
          busy_o       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_r6_vsum.sv
// Scoreboard bench for r6_vsum: stimulus pushes hand-derived expected sums,
// a negedge monitor pops and compares whenever valid_o is presented.
module tb_r6_vsum;
  localparam int COLS = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_i = 1'b0, valid_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_o, done_o, row_eq_max_o, busy_o;
  logic [11:0] sum_o;
  logic [9:0]  col_o, row_o, counter_o;

  logic        start10 = 1'b0, valid10 = 1'b0;
  logic [7:0]  data10 = '0;
  logic        valid_o10, done_o10, reqm10, busy10;
  logic [11:0] sum10;
  logic [9:0]  col10, row10, cnt10;

  r6_vsum dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .sum_o(sum_o), .col_o(col_o), .row_o(row_o), .done_o(done_o),
    .counter_o(counter_o), .row_eq_max_o(row_eq_max_o), .busy_o(busy_o));

  r6_vsum #(.ROWS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start_i(start10), .valid_i(valid10), .data_i(data10),
    .valid_o(valid_o10), .sum_o(sum10), .col_o(col10), .row_o(row10), .done_o(done_o10),
    .counter_o(cnt10), .row_eq_max_o(reqm10), .busy_o(busy10));

  always #5 clk = ~clk;

  typedef struct {int sum; int col; int row; bit done;} exp_t;
  exp_t q[$];
  int n_pass = 0, n_total = 0, n_out = 0, n_done = 0, n_bad10 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      n_out++;
      if (done_o) n_done++;
      if (q.size() == 0) chk("unexpected_valid_o", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sum_o", int'(sum_o), e.sum);
        chk("col_o", int'(col_o), e.col);
        chk("row_o", int'(row_o), e.row);
        chk("done_o", int'(done_o), int'(e.done));
      end
    end else if (done_o) chk("done_without_valid", 1, 0);
    if (valid_o10 || done_o10) n_bad10++;
  end

  task automatic start_frame();
    start_i = 1'b1; valid_i = 1'b1; data_i = 8'hAA;
    @(posedge clk); #1;
    start_i = 1'b0; valid_i = 1'b0;
    n_out = 0; n_done = 0;
    chk("busy_after_start", int'(busy_o), 1);
    chk("reqm_after_start", int'(row_eq_max_o), 0);
  endtask

  // mode 0: every pixel = v; mode 1: pixel = row index
  task automatic send(input int mode, input int v, input int npix, input int gap);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      exp_t e;
      r = i / COLS;
      c = i % COLS;
      while (gap > 0 && $urandom_range(99) < gap) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
      end
      chk("counter_o", int'(counter_o), c);
      valid_i = 1'b1;
      data_i  = (mode == 1) ? 8'(r) : 8'(v);
      if (r >= 12) begin
        e.sum  = (mode == 1) ? 13 * (r - 6) : 13 * v;
        e.col  = c;
        e.row  = r - 6;
        e.done = (r == 12 && c == 0);
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic frame_end(input int nout);
    chk("row_eq_max_o", int'(row_eq_max_o), 1);
    chk("busy_in_done", int'(busy_o), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("n_outputs", n_out, nout);
    chk("n_done", n_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_sum_o", int'(sum_o), 0);
    chk("rst_col_o", int'(col_o), 0);
    chk("rst_row_o", int'(row_o), 0);
    chk("rst_done_o", int'(done_o), 0);
    chk("rst_counter_o", int'(counter_o), 0);
    chk("rst_row_eq_max_o", int'(row_eq_max_o), 0);
    chk("rst_busy_o", int'(busy_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all ones, continuous
    start_frame();
    send(0, 1, 225, 0);
    frame_end(45);
    // DONE ignores pixels
    valid_i = 1'b1; data_i = 8'd9;
    repeat (5) @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("done_counter_hold", int'(counter_o), 0);
    chk("done_reqm_hold", int'(row_eq_max_o), 1);

    // pixel = row index
    start_frame();
    send(1, 0, 225, 0);
    frame_end(45);

    // saturated pixels
    start_frame();
    send(0, 255, 225, 0);
    frame_end(45);

    // restart mid-frame, then value 2
    start_frame();
    send(0, 7, 5 * COLS + 3, 0);
    start_frame();
    send(0, 2, 225, 0);
    frame_end(45);

    // async reset mid-frame
    start_frame();
    send(0, 1, 13 * COLS + 5, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_o", int'(valid_o), 0);
    chk("arst_sum_o", int'(sum_o), 0);
    chk("arst_busy_o", int'(busy_o), 0);
    chk("arst_counter_o", int'(counter_o), 0);
    chk("arst_col_o", int'(col_o), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b1; data_i = 8'd5;
    repeat (20) @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("idle_busy_o", int'(busy_o), 0);
    chk("idle_counter_o", int'(counter_o), 0);
    chk("idle_queue_empty", q.size(), 0);

    // all ones with ~40% gaps
    start_frame();
    send(0, 1, 225, 40);
    frame_end(45);

    // ROWS=10 build: no outputs, DONE after 150 pixels
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    chk("r10_busy", int'(busy10), 1);
    for (int i = 0; i < 150; i++) begin
      valid10 = 1'b1; data10 = 8'd1;
      if (i == 149) chk("r10_reqm_before_last", int'(reqm10), 0);
      @(posedge clk); #1;
    end
    valid10 = 1'b0;
    chk("r10_reqm_after_last", int'(reqm10), 1);
    chk("r10_busy_done", int'(busy10), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("r10_no_valid_or_done", n_bad10, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
